// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch stage.
package ifetch_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Sync FIFO of fetch entries; head visible the cycle after push.
// No overflow guard: the writer only pushes into slots it reserved earlier. Flush wins over push and pop.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_vld,
   input  fetch_entry_t                 push_dat,
   input  logic                         pop_vld,
   input  logic                         flush,
   output fetch_entry_t                 head_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push  = push_vld && !flush;
   assign do_pop   = pop_vld && !flush && (count != '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns fetch PC, issues in-order imem requests, drops stale words after redirect; rsp->instr_valid 1 cycle.
// Requests throttled so every response has a buffer slot; stall holds the head. `IFETCH_MISALIGN_CHK_EN adds fetch_misalign.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc
`ifdef IFETCH_MISALIGN_CHK_EN
   ,
   output logic        fetch_misalign
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   redir_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] drop_nxt;
   logic [CW-1:0] fifo_count;
   logic          req_fire;
   logic          keep_rsp;
   logic          halt;
   fetch_entry_t  head;

   // Reserving a buffer slot per in-flight request lets responses be accepted unconditionally.
   assign imem_req_valid = (state != S_BOOT) && !halt &&
                           (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign redir_pc       = redirect_pc & 32'hFFFF_FFFC;
   assign keep_rsp       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

   always_comb begin
      drop_nxt = drop_cnt;
      if (redirect_valid)                          drop_nxt = outstanding_nxt;
      else if (imem_rsp_valid && drop_cnt != '0)   drop_nxt = drop_cnt - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_BOOT;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_nxt;
         if (redirect_valid) begin
            fetch_pc <= redir_pc;
            rsp_pc   <= redir_pc;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (keep_rsp) rsp_pc   <= rsp_pc + 32'd4;
         end
         case (state)
            S_BOOT:  state <= S_RUN;
            default: state <= (drop_nxt != '0) ? S_FLUSH : S_RUN;
         endcase
      end
   end

`ifdef IFETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               fetch_misalign <= 1'b0;
      else if (redirect_valid) fetch_misalign <= (redirect_pc[1:0] != 2'b00);
   end
   assign halt = fetch_misalign;
`else
   assign halt = 1'b0;
`endif

   ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (keep_rsp),
      .push_dat ('{pc: rsp_pc, instr: imem_rsp_data}),
      .pop_vld  (instr_valid && !stall),
      .flush    (redirect_valid),
      .head_dat (head),
      .count    (fifo_count)
   );

   assign instr_valid = (fifo_count != '0);
   assign instruction = instr_valid ? head.instr : NOP_INSTR;
   assign instr_pc    = instr_valid ? head.pc : 32'h0;

   a_outstanding_max: assert property (@(posedge clk) disable iff (reset)
      outstanding <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory model with random latency and a tag-based reference of the decode stream.
module tb_ifetch_unit;
   import ifetch_pkg::*;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stall = 1'b0;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
   logic        fetch_misalign;
`endif

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .instr_valid    (instr_valid),
      .instruction    (instruction),
      .instr_pc       (instr_pc)
`ifdef IFETCH_MISALIGN_CHK_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   // In-flight request as seen by memory; stale = issued before a later redirect.
   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   mreq_t       mem_q[$];
   logic [31:0] buf_q[$];
   logic [31:0] m_fetch;
   bit          m_boot;
   bit          m_mis;
   int          cyc;
   int          last_due;
   int          first_vld_cyc;
   int          n_tests = 0;
   int          n_fail = 0;
   int          p_ready, p_stall, p_redir, lat_min, lat_max;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = 32'h0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit model_req_vld();
      return !m_boot && !m_mis && ((mem_q.size() + buf_q.size()) < DEPTH);
   endfunction

   task automatic model_reset();
      mem_q.delete();
      buf_q.delete();
      m_fetch       = RST_PC;
      m_boot        = 1'b1;
      m_mis         = 1'b0;
      cyc           = 0;
      last_due      = 0;
      first_vld_cyc = -1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_req_vld"}, imem_req_valid, 32'd0);
      check_val({tag, "_req_addr"}, imem_req_addr, RST_PC);
      check_val({tag, "_instr_vld"}, instr_valid, 32'd0);
      check_val({tag, "_instr"}, instruction, NOP_INSTR);
      check_val({tag, "_instr_pc"}, instr_pc, 32'd0);
`ifdef IFETCH_MISALIGN_CHK_EN
      check_val({tag, "_misalign"}, fetch_misalign, 32'd0);
`endif
   endtask

   // Called at a falling edge: check outputs, drive this cycle's inputs, advance the model past the next rising edge.
   task automatic step();
      bit          acc, pop, have_rsp;
      mreq_t       r;
      mreq_t       n;
      logic [31:0] rp;
      int          lat;

      check_val("req_vld", imem_req_valid, model_req_vld());
      check_val("req_addr", imem_req_addr, m_fetch);
      check_val("instr_vld", instr_valid, buf_q.size() > 0);
      if (buf_q.size() > 0) begin
         check_val("instr_pc", instr_pc, buf_q[0]);
         check_val("instr", instruction, word_of(buf_q[0]));
      end else begin
         check_val("idle_instr", instruction, NOP_INSTR);
         check_val("idle_pc", instr_pc, 32'd0);
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      check_val("misalign", fetch_misalign, m_mis);
`endif
      if (instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;

      imem_req_ready = ($urandom_range(99) < p_ready);
      stall          = ($urandom_range(99) < p_stall);
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_pc;
         force_redir    = 1'b0;
      end else begin
         redirect_valid = ($urandom_range(99) < p_redir);
         redirect_pc    = $urandom & 32'hFFFF_FFFC;
      end
      rp = redirect_pc;

      acc = model_req_vld() && imem_req_ready;
      pop = (buf_q.size() > 0) && !stall;
      have_rsp = (mem_q.size() > 0) && (mem_q[0].due == cyc);
      if (have_rsp) begin
         r = mem_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_of(r.addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end

      if (acc) begin
         lat        = $urandom_range(lat_max, lat_min);
         n.addr     = m_fetch;
         n.due      = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         n.stale    = 1'b0;
         last_due   = n.due;
         mem_q.push_back(n);
      end
      if (redirect_valid) begin
         buf_q.delete();
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         m_fetch = rp & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHK_EN
         m_mis = (rp[1:0] != 2'b00);
`endif
      end else begin
         if (pop) void'(buf_q.pop_front());
         if (have_rsp && !r.stale) buf_q.push_back(r.addr);
         if (acc) m_fetch = m_fetch + 32'd4;
      end
      m_boot = 1'b0;

      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_instr(input string tag, input logic [31:0] exp_pc);
      int k = 0;
      while (!instr_valid && k < 30) begin
         step();
         k++;
      end
      check_val({tag, "_seen"}, instr_valid, 32'd1);
      check_val({tag, "_pc"}, instr_pc, exp_pc);
      check_val({tag, "_instr"}, instruction, word_of(exp_pc));
   endtask

   initial begin
      logic [31:0] hold_pc, hold_addr;
      int          k;

      model_reset();
      p_ready = 100; p_stall = 0; p_redir = 0; lat_min = 1; lat_max = 1;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");

      // Bring-up with single-cycle memory.
      reset = 1'b0;
      repeat (12) step();
      check_val("first_vld_cycle", 32'(first_vld_cyc), 32'd3);

      // Decode stall fills the buffer and throttles requests.
      p_stall = 100;
      repeat (3) step();
      hold_pc = instr_pc;
      repeat (5) step();
      check_val("stall_req_vld", imem_req_valid, 32'd0);
      check_val("stall_vld", instr_valid, 32'd1);
      check_val("stall_hold_pc", instr_pc, hold_pc);
      p_stall = 0;
      repeat (6) step();

      // Memory not ready: request held with a stable address.
      p_ready = 0;
      repeat (4) step();
      hold_addr = imem_req_addr;
      repeat (4) step();
      check_val("nrdy_req_vld", imem_req_valid, 32'd1);
      check_val("nrdy_addr", imem_req_addr, hold_addr);
      p_ready = 100;
      repeat (6) step();

      // Redirect with two requests in flight.
      lat_min = 3; lat_max = 3;
      k = 0;
      while (mem_q.size() != 2 && k < 20) begin
         step();
         k++;
      end
      check_val("t4_inflight", mem_q.size(), 32'd2);
      force_redir = 1'b1; force_pc = 32'h0000_0100;
      step();
      wait_instr("t4", 32'h0000_0100);
      repeat (4) step();

      // Redirect in the same cycle as a response and an accepted request.
      lat_min = 1; lat_max = 2;
      k = 0;
      while (!(mem_q.size() > 0 && mem_q[0].due == cyc && model_req_vld()) && k < 60) begin
         step();
         k++;
      end
      check_val("t5_found", (k < 60), 32'd1);
      force_redir = 1'b1; force_pc = 32'h0000_0200;
      step();
      wait_instr("t5", 32'h0000_0200);
      repeat (10) step();

      // Reset mid-stream; responses during reset are junk.
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      imem_rsp_valid = 1'b0;
      model_reset();
      lat_min = 1; lat_max = 1;
      reset = 1'b0;
      repeat (12) step();
      check_val("midrst_first_vld", 32'(first_vld_cyc), 32'd3);

`ifdef IFETCH_MISALIGN_CHK_EN
      force_redir = 1'b1; force_pc = 32'h0000_0102;
      step();
      check_val("mis_flag", fetch_misalign, 32'd1);
      repeat (4) step();
      check_val("mis_no_req", imem_req_valid, 32'd0);
      force_redir = 1'b1; force_pc = 32'h0000_0300;
      step();
      check_val("mis_clear", fetch_misalign, 32'd0);
      wait_instr("mis_resume", 32'h0000_0300);
`endif

      // Random traffic.
      p_ready = 70; p_stall = 30; p_redir = 5; lat_min = 1; lat_max = 4;
      repeat (3000) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
